// File: rtl/wash_pkg.sv
// Shared definitions for the washer front-panel buttons.
// Button indices, channel count and the per-channel debounce state encoding.
package wash_pkg;

  localparam int NUM_BTN   = 4;
  localparam int BTN_POWER = 0;
  localparam int BTN_SS    = 1;
  localparam int BTN_MOD   = 2;
  localparam int BTN_WATER = 3;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PRESS_CHK = 2'd1,
    HELD      = 2'd2,
    REL_CHK   = 2'd3
  } btn_state_e;

endpackage

// File: rtl/btn_debounce_ch.sv
// One button channel: 2-flop synchronizer, debounce FSM, long-hold timer.
// Press/release pulses DEB_CYCLES+3 edges after a clean input edge; no backpressure.
module btn_debounce_ch
  import wash_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic btn_long,
  output logic press_next
);

  localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
  localparam int LONG_W = (LONG_CYCLES > 1) ? $clog2(LONG_CYCLES) : 1;
  localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
  localparam logic [LONG_W-1:0] LONG_LAST = LONG_W'(LONG_CYCLES - 1);

  logic              sync_q1;
  logic              sync;
  btn_state_e        state, state_nxt;
  logic [DEB_W-1:0]  deb_cnt, deb_cnt_nxt;
  logic [LONG_W-1:0] long_cnt, long_cnt_nxt;
  logic              long_fired, long_fired_nxt;
  logic              level_nxt, press_nxt, release_nxt, long_nxt;

  always_comb begin
    state_nxt      = state;
    deb_cnt_nxt    = deb_cnt;
    long_cnt_nxt   = long_cnt;
    long_fired_nxt = long_fired;
    level_nxt      = btn_level;
    press_nxt      = 1'b0;
    release_nxt    = 1'b0;
    long_nxt       = 1'b0;

    // Hold time keeps running through a release check so a short dropout
    // does not shift the long-press moment.
    if ((state == HELD || state == REL_CHK) && long_cnt != LONG_LAST)
      long_cnt_nxt = long_cnt + 1'b1;

    case (state)
      IDLE: begin
        if (sync) begin
          state_nxt   = PRESS_CHK;
          deb_cnt_nxt = '0;
        end
      end
      PRESS_CHK: begin
        if (!sync) begin
          state_nxt = IDLE;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt      = HELD;
          press_nxt      = 1'b1;
          level_nxt      = 1'b1;
          long_cnt_nxt   = '0;
          long_fired_nxt = 1'b0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      HELD: begin
        if (long_cnt == LONG_LAST && !long_fired) begin
          long_nxt       = 1'b1;
          long_fired_nxt = 1'b1;
        end
        if (!sync) begin
          state_nxt   = REL_CHK;
          deb_cnt_nxt = '0;
        end
      end
      REL_CHK: begin
        if (sync) begin
          state_nxt = HELD;
        end else if (deb_cnt == DEB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
          level_nxt   = 1'b0;
        end else begin
          deb_cnt_nxt = deb_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q1     <= 1'b0;
      sync        <= 1'b0;
      state       <= IDLE;
      deb_cnt     <= '0;
      long_cnt    <= '0;
      long_fired  <= 1'b0;
      btn_level   <= 1'b0;
      btn_press   <= 1'b0;
      btn_release <= 1'b0;
      btn_long    <= 1'b0;
    end else begin
      sync_q1     <= btn_raw;
      sync        <= sync_q1;
      state       <= state_nxt;
      deb_cnt     <= deb_cnt_nxt;
      long_cnt    <= long_cnt_nxt;
      long_fired  <= long_fired_nxt;
      btn_level   <= level_nxt;
      btn_press   <= press_nxt;
      btn_release <= release_nxt;
      btn_long    <= long_nxt;
    end
  end

  assign press_next = press_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Debounces the four panel buttons and flags any accepted press for the blink logic.
// Pulses DEB_CYCLES+3 edges after a clean input edge; no backpressure.
module button_conditioner
  import wash_pkg::*;
#(
  parameter int DEB_CYCLES  = 500000,
  parameter int LONG_CYCLES = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_BTN-1:0] btn_raw,
  output logic [NUM_BTN-1:0] btn_level,
  output logic [NUM_BTN-1:0] btn_press,
  output logic [NUM_BTN-1:0] btn_release,
  output logic [NUM_BTN-1:0] btn_long,
  output logic               any_press
);

  logic [NUM_BTN-1:0] press_next;

  for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
    btn_debounce_ch #(
      .DEB_CYCLES  (DEB_CYCLES),
      .LONG_CYCLES (LONG_CYCLES)
    ) u_ch (
      .clk         (clk),
      .rst_n       (rst_n),
      .btn_raw     (btn_raw[i]),
      .btn_level   (btn_level[i]),
      .btn_press   (btn_press[i]),
      .btn_release (btn_release[i]),
      .btn_long    (btn_long[i]),
      .press_next  (press_next[i])
    );
  end

  // Registered from the channels' next-cycle press so it lines up with btn_press.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) any_press <= 1'b0;
    else        any_press <= |press_next;
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed vector table, corner sequences,
// then randomized bouncing inputs against a run-length reference model.
module tb_button_conditioner;

  localparam int DEB  = 4;
  localparam int LONG = 20;

  logic       clk;
  logic       rst_n;
  logic [3:0] btn_raw;
  logic [3:0] btn_level, btn_press, btn_release, btn_long;
  logic       any_press;
  wire  [16:0] dut_out = {btn_level, btn_press, btn_release, btn_long, any_press};

  int checks = 0;
  int errors = 0;

  button_conditioner #(.DEB_CYCLES(DEB), .LONG_CYCLES(LONG)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .btn_raw     (btn_raw),
    .btn_level   (btn_level),
    .btn_press   (btn_press),
    .btn_release (btn_release),
    .btn_long    (btn_long),
    .any_press   (any_press)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: an input change is accepted once the synchronized value
  // has differed from the accepted level on DEB+1 consecutive edges; the long
  // pulse comes LONG edges after the press, only while not re-checking a release.
  logic [3:0] m_s1, m_s2, m_level, m_press, m_release, m_long;
  int         m_run [4];
  int         m_age [4];
  bit         m_fired [4];

  task automatic model_edge();
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_level = '0;
      m_press = '0; m_release = '0; m_long = '0;
      for (int i = 0; i < 4; i++) begin
        m_run[i] = 0; m_age[i] = 0; m_fired[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        m_press[i] = 1'b0; m_release[i] = 1'b0; m_long[i] = 1'b0;
        if (m_level[i] && m_run[i] == 0 && m_age[i] >= LONG - 1 && !m_fired[i]) begin
          m_long[i]  = 1'b1;
          m_fired[i] = 1;
        end
        if (m_s2[i] != m_level[i]) m_run[i]++;
        else                       m_run[i] = 0;
        if (m_run[i] == DEB + 1) begin
          m_run[i]   = 0;
          m_level[i] = ~m_level[i];
          if (m_level[i]) begin
            m_press[i] = 1'b1; m_age[i] = 0; m_fired[i] = 0;
          end else begin
            m_release[i] = 1'b1;
          end
        end else begin
          m_age[i]++;
        end
      end
      m_s2 = m_s1;
      m_s1 = btn_raw;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [3:0] raw;
    int         reps;
    logic [3:0] lvl, prs, rel, lng;
    logic       any;
  } vec_t;

  vec_t       vecs[$];
  logic [3:0] acc_pulse, acc_level, acc_rel;
  int         long_seen;
  int         hold [4];

  initial begin
    rst_n   = 1'b0;
    btn_raw = '0;
    #1;
    check("reset_async", 32'(dut_out), 32'h0);
    tick(); tick();
    check("reset_hold", 32'(dut_out), 32'h0);
    rst_n = 1'b1;
    tick();
    check("reset_exit", 32'(dut_out), 32'h0);

    // Clean press/hold/release on power, then a simultaneous power+water press.
    vecs.push_back('{4'b0001,  6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001,  1, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{4'b0001, 19, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0001,  1, 4'b0001, 4'b0000, 4'b0000, 4'b0001, 1'b0});
    vecs.push_back('{4'b0001, 13, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  6, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  1, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  3, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b1001,  6, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b1001,  1, 4'b1001, 4'b1001, 4'b0000, 4'b0000, 1'b1});
    vecs.push_back('{4'b1001,  3, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  6, 4'b1001, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  1, 4'b0000, 4'b0000, 4'b1001, 4'b0000, 1'b0});
    vecs.push_back('{4'b0000,  2, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0});
    foreach (vecs[v]) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        btn_raw = vecs[v].raw;
        tick();
        check($sformatf("vec%0d_cyc%0d", v, r), 32'(dut_out),
              32'({vecs[v].lvl, vecs[v].prs, vecs[v].rel, vecs[v].lng, vecs[v].any}));
      end
    end

    // Bounce on mod: 2 high / 1 low six times must be rejected entirely.
    acc_pulse = '0; acc_level = '0;
    for (int k = 0; k < 6; k++) begin
      btn_raw = 4'b0100; tick();
      acc_pulse |= btn_press | btn_release | btn_long | {3'b0, any_press};
      acc_level |= btn_level;
      tick();
      acc_pulse |= btn_press | btn_release | btn_long | {3'b0, any_press};
      acc_level |= btn_level;
      btn_raw = 4'b0000; tick();
      acc_pulse |= btn_press | btn_release | btn_long | {3'b0, any_press};
      acc_level |= btn_level;
    end
    for (int k = 0; k < 8; k++) begin
      tick();
      acc_pulse |= btn_press | btn_release | btn_long | {3'b0, any_press};
      acc_level |= btn_level;
    end
    check("bounce_pulses", 32'(acc_pulse), 32'h0);
    check("bounce_level", 32'(acc_level), 32'h0);

    // Two-cycle dropout on ss during a hold: no release, long timing unchanged.
    acc_rel = '0; long_seen = 0; acc_level = 4'b1111;
    for (int e = 1; e <= 34; e++) begin
      btn_raw = (e == 10 || e == 11) ? 4'b0000 : 4'b0010;
      tick();
      if (e == 7) check("glitch_press", 32'({btn_press, any_press}), 32'({4'b0010, 1'b1}));
      if (e == 27) check("glitch_long_edge", 32'(btn_long), 32'h2);
      if (e >= 7) acc_level &= btn_level;
      acc_rel |= btn_release;
      if (btn_long[1]) long_seen++;
    end
    check("glitch_no_release", 32'(acc_rel), 32'h0);
    check("glitch_level_held", 32'(acc_level[1]), 32'h1);
    check("glitch_long_once", 32'(long_seen), 32'h1);
    btn_raw = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e == 6) check("glitch_rel_pending", 32'({btn_level, btn_release}), 32'h20);
    end
    check("glitch_release", 32'({btn_level, btn_release}), 32'h02);

    // Water held while reset pulses mid-debounce: press restarts from reset release.
    btn_raw = 4'b1000;
    for (int e = 1; e <= 5; e++) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_async", 32'(dut_out), 32'h0);
    tick();
    check("rst_mid_hold", 32'(dut_out), 32'h0);
    rst_n = 1'b1;
    for (int e = 1; e <= 7; e++) begin
      tick();
      if (e < 7) check($sformatf("rst_mid_wait%0d", e), 32'({btn_press, any_press}), 32'h0);
    end
    check("rst_mid_press", 32'({btn_level, btn_press, any_press}), 32'({4'b1000, 4'b1000, 1'b1}));
    // Reset landing on the pulse cycle must kill it at once.
    rst_n = 1'b0;
    #1;
    check("rst_abort_pulse", 32'(dut_out), 32'h0);
    tick();
    rst_n   = 1'b1;
    btn_raw = 4'b0000;
    for (int e = 0; e < 4; e++) tick();
    check("rst_abort_idle", 32'(dut_out), 32'h0);

    // Randomized bouncing/holding on all channels against the model.
    for (int i = 0; i < 4; i++) hold[i] = 0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (hold[i] == 0) begin
          btn_raw[i] = ~btn_raw[i];
          hold[i] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 45))
                                                : int'($urandom_range(1, 8));
        end
        hold[i]--;
      end
      if (c == 1500) rst_n = 1'b0;
      if (c == 1502) rst_n = 1'b1;
      tick();
      check($sformatf("rand_cyc%0d", c), 32'(dut_out),
            32'({m_level, m_press, m_release, m_long, |m_press}));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/button_conditioner.md
BUTTON_CONDITIONER -- requirements
Module: button_conditioner

Interface
REQ-001 Parameter DEB_CYCLES, default 500000, is the number of cycles a synchronized input must be stable before it is accepted (10 ms at 50 MHz).
REQ-002 Parameter LONG_CYCLES, default 100000000, is the number of held cycles after the press pulse before the long pulse fires (2 s); it SHALL be greater than DEB_CYCLES.
REQ-003 clk  in  1  system clock, 50 MHz.
REQ-004 rst_n  in  1  reset, asynchronous, active-low.
REQ-005 btn_raw  in  4  raw push-buttons; bit0 power, bit1 ss, bit2 mod, bit3 water; asynchronous and bouncing.
REQ-006 btn_level  out  4  debounced level per button.
REQ-007 btn_press  out  4  one-cycle pulse per accepted press.
REQ-008 btn_release  out  4  one-cycle pulse per accepted release.
REQ-009 btn_long  out  4  one-cycle pulse, at most once per hold.
REQ-010 any_press  out  1  OR of btn_press, asserted in the same cycle; this is the blink-trigger input for the controller.

Function
REQ-011 Each bit SHALL pass through a 2-flop synchronizer; the second flop is "sync".
REQ-012 Each channel SHALL run an FSM with the states IDLE, PRESS_CHK, HELD and REL_CHK, plus a debounce counter and a long counter.
REQ-013 IDLE: on sync=1, go to PRESS_CHK and set deb_cnt=0.
REQ-014 PRESS_CHK: on sync=0, return to IDLE with no output (bounce rejected).
REQ-015 PRESS_CHK: on sync=1 and deb_cnt==DEB_CYCLES-1, go to HELD, pulse btn_press, set btn_level=1 and long_cnt=0.
REQ-016 PRESS_CHK: otherwise increment deb_cnt.
REQ-017 HELD: on sync=0, go to REL_CHK with deb_cnt=0.
REQ-018 HELD: otherwise, if long_cnt<LONG_CYCLES-1, increment long_cnt.
REQ-019 HELD: btn_long SHALL pulse on the cycle long_cnt reaches LONG_CYCLES-1; long_cnt then saturates and does not pulse again.
REQ-020 REL_CHK: on sync=1, return to HELD with long_cnt preserved and no pulse.
REQ-021 REL_CHK: on deb_cnt==DEB_CYCLES-1, go to IDLE, pulse btn_release and set btn_level=0.
REQ-022 REL_CHK: otherwise increment deb_cnt.
REQ-023 Press latency: with btn_raw rising and held stable, btn_press SHALL be high for exactly the cycle after clock edge DEB_CYCLES+3, counting the first edge that samples the high as edge 1.
REQ-024 Release latency SHALL be symmetric to press latency.
REQ-025 All outputs SHALL be registered; btn_press, btn_release and btn_long are never high for more than one consecutive cycle.
REQ-026 btn_press and btn_release of one channel SHALL never be high in the same cycle.
REQ-027 Channels SHALL be fully independent; simultaneous presses on several bits SHALL give simultaneous pulses.
REQ-028 deb_cnt width SHALL be $clog2(DEB_CYCLES); long_cnt width SHALL be $clog2(LONG_CYCLES).
REQ-029 The counters SHALL never wrap.

Reset
REQ-030 While rst_n=0, all of the following SHALL be 0: synchronizer flops, counters, btn_level, btn_press, btn_release, btn_long and any_press; every FSM SHALL be in IDLE.
REQ-031 Reset asserted mid-operation SHALL abort any pending press, release or long pulse immediately.
REQ-032 A button held through reset deassertion SHALL be detected as a new press after the normal REQ-023 latency.

Structure
REQ-033 Package wash_pkg SHALL hold the button index constants (BTN_POWER=0, BTN_SS=1, BTN_MOD=2, BTN_WATER=3), NUM_BTN=4 and the channel-state enum.
REQ-034 Sub-module btn_debounce_ch SHALL implement one channel (synchronizer, FSM, counters).
REQ-035 The top level SHALL instantiate NUM_BTN copies of btn_debounce_ch and form any_press.

Verification
Scenarios 1-5 use DEB_CYCLES=4 and LONG_CYCLES=20.
REQ-036 Clean press: btn_raw[0] rises, held for 40 cycles -> btn_press[0] high only in the cycle after edge 7, any_press high in the same cycle, btn_level[0]=1 from that cycle; btn_long[0] pulses once, 20 cycles after btn_press.
REQ-037 Bounce: btn_raw[2] toggles high 2 cycles / low 1 cycle, six times, then low -> no pulses and btn_level[2] stays 0.
REQ-038 Release glitch: during a hold, btn_raw[1] drops for 2 cycles -> no btn_release[1], btn_level[1] stays 1, and btn_long[1] timing is unchanged.
REQ-039 Simultaneous press: btn_raw=4'b1001 rises in one cycle -> btn_press=4'b1001 in a single cycle and any_press=1 for that one cycle.
REQ-040 Reset mid-debounce: btn_raw[3] held high, rst_n pulsed low after edge 5 -> all outputs are 0 during reset; btn_press[3] is high only in the cycle after edge 7 following reset release.
